// File: rtl/ahb_xfer_ctrl_pkg.sv
// Shared AHB-Lite encodings, controller state and burst helpers for the
// I-cache front-end transfer controller.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        XS_IDLE,
        XS_RD,
        XS_ERR1,
        XS_ERR2
    } xfer_state_t;

    // Per-transfer context captured at the address phase.
    typedef struct packed {
        logic [2:0] size;
        hburst_t    burst;
        logic [3:0] beat;
        logic [4:0] len;
    } burst_ctx_t;

    // Beat count of a fixed-length burst; 0 means unbounded (SINGLE/INCR).
    function automatic logic [4:0] burst_len(input hburst_t b);
        case (b)
            HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
            default:                      burst_len = 5'd0;
        endcase
    endfunction

    function automatic logic [2:0] burst_len_log2(input hburst_t b);
        case (b)
            HBURST_WRAP4,  HBURST_INCR4:  burst_len_log2 = 3'd2;
            HBURST_WRAP8,  HBURST_INCR8:  burst_len_log2 = 3'd3;
            HBURST_WRAP16, HBURST_INCR16: burst_len_log2 = 3'd4;
            default:                      burst_len_log2 = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_xfer_ctrl_burst_addr_gen.sv
// Expected next SEQ address of an AHB burst from the previous beat address.
// Pure combinational so the D-side controller can share it.
module ahb_burst_addr_gen
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] prev_addr,
    input  logic [2:0]        hsize,
    input  hburst_t           hburst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;
    logic              wrap;

    assign step      = ADDR_W'(1) << hsize;
    assign incr_addr = prev_addr + step;
    assign wrap      = (hburst == HBURST_WRAP4) || (hburst == HBURST_WRAP8) ||
                       (hburst == HBURST_WRAP16);
    // Wrap boundary is len * 2^hsize bytes; only the low bits advance.
    assign wrap_mask = (ADDR_W'(1) << (32'(hsize) + 32'(burst_len_log2(hburst))))
                       - ADDR_W'(1);
    assign next_addr = wrap ? ((prev_addr & ~wrap_mask) | (incr_addr & wrap_mask))
                            : incr_addr;

endmodule

// File: rtl/ahb_xfer_ctrl.sv
// AHB-Lite read-only slave front end for the I-cache: turns address phases
// into cache lookups, stalls until the cache answers, errors writes/oversize.
module ahb_xfer_ctrl
    import ahb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_SIZE = $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    output logic              req_last,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              seq_err
);

    xfer_state_t       state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    burst_ctx_t        ctx_q;
    logic              seq_err_q;
    logic [ADDR_W-1:0] exp_addr;
    logic              can_accept;
    logic              accept;
    logic              bad_xfer;

    ahb_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .prev_addr (addr_q),
        .hsize     (ctx_q.size),
        .hburst    (ctx_q.burst),
        .next_addr (exp_addr)
    );

    // A new address phase is only taken when our own data phase is completing.
    assign can_accept = (state == XS_IDLE) || (state == XS_ERR2) ||
                        ((state == XS_RD) && rsp_valid);
    assign accept     = can_accept && hsel && hready && htrans[1];
    assign bad_xfer   = hwrite || (hsize > 3'(MAX_SIZE));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= XS_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            XS_RD: begin
                if (rsp_valid)
                    state_nxt = accept ? (bad_xfer ? XS_ERR1 : XS_RD) : XS_IDLE;
            end
            XS_ERR1: state_nxt = XS_ERR2;
            default: state_nxt = accept ? (bad_xfer ? XS_ERR1 : XS_RD) : XS_IDLE;
        endcase
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        hrdata    = '0;
        req_valid = 1'b0;
        req_last  = 1'b0;
        seq_err   = 1'b0;
        case (state)
            XS_RD: begin
                req_valid = 1'b1;
                hreadyout = rsp_valid;
                if (rsp_valid) hrdata = rsp_data;
                req_last  = (ctx_q.burst == HBURST_SINGLE) ||
                            ((ctx_q.len != 5'd0) && ({1'b0, ctx_q.beat} == ctx_q.len - 5'd1));
                seq_err   = seq_err_q;
            end
            XS_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
            end
            XS_ERR2: hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    assign req_addr = addr_q;

    // SEQ beats are checked against the address predicted from the previous beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q    <= '0;
            ctx_q     <= '0;
            seq_err_q <= 1'b0;
        end else if (accept) begin
            addr_q     <= haddr;
            ctx_q.size <= hsize;
            ctx_q.burst <= hburst_t'(hburst);
            if (htrans_t'(htrans) == HTRANS_NONSEQ) begin
                ctx_q.beat <= 4'd0;
                ctx_q.len  <= burst_len(hburst_t'(hburst));
                seq_err_q  <= 1'b0;
            end else begin
                ctx_q.beat <= ctx_q.beat + 4'd1;
                seq_err_q  <= (haddr != exp_addr);
            end
        end
    end

endmodule
